// File: rtl/scale_line_sched.sv
// scale_line_sched: accepts a valid/ready pixel stream into scale_fifo and releases one
// full line per downstream line request as a fixed-length read burst, followed by a
// configurable idle gap. The block keeps its own FIFO occupancy count and flags underflow.
module scale_line_sched #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 11,
    parameter int LINE_LEN    = 1024,
    parameter int FILL_LIMIT  = 2040,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   tb_rst,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [DATA_WIDTH-1:0]  fifo_wr_data,
    output logic                   fifo_wr_en,
    input  logic                   fifo_wr_full,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic                   line_req,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    output logic                   m_last,
    output logic [DEPTH_WIDTH:0]   level,
    output logic [15:0]            lines_done,
    output logic                   udf_err
);

    localparam int LW = DEPTH_WIDTH + 1;
    localparam logic [LW-1:0] LINE_LEN_C = LW'(LINE_LEN);
    localparam logic [LW-1:0] FILL_C     = LW'(FILL_LIMIT);
    localparam logic [LW-1:0] LAST_PIX   = LW'(LINE_LEN - 1);
    localparam logic [15:0]   GAP_LAST   = 16'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state_r;
    logic [LW-1:0]   pix_cnt_r;
    logic [15:0]     gap_cnt_r;
    logic            req_pend_r;
    logic [LW-1:0]   level_r;
    logic [15:0]     lines_done_r;
    logic            rd_en_r;
    logic            m_valid_r;
    logic            m_last_r;
    logic            udf_err_r;

    logic            s_ready_s;
    logic            wr_en_s;
    logic            start_s;
    logic            last_rd_s;

    // Input acceptance, burst start decision and last-read detection.
    always_comb begin
        s_ready_s = 1'b0;
        wr_en_s   = 1'b0;
        start_s   = 1'b0;
        last_rd_s = 1'b0;
        if (!fifo_wr_full && (level_r < FILL_C)) begin
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = 1'b0;
        end
        wr_en_s = s_valid && s_ready_s;
        if ((state_r == IDLE) && req_pend_r && (level_r >= LINE_LEN_C)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
        if ((state_r == BURST) && (pix_cnt_r == LAST_PIX)) begin
            last_rd_s = 1'b1;
        end else begin
            last_rd_s = 1'b0;
        end
    end

    // Occupancy count: a write and a read in the same cycle cancel out.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            level_r <= {LW{1'b0}};
        end else begin
            case ({wr_en_s, rd_en_r})
                2'b10: begin
                    level_r <= level_r + LW'(1);
                end
                2'b01: begin
                    if (level_r != {LW{1'b0}}) begin
                        level_r <= level_r - LW'(1);
                    end else begin
                        level_r <= level_r;
                    end
                end
                default: begin
                    level_r <= level_r;
                end
            endcase
        end
    end

    // One-deep line request latch; a new request wins over the clear at burst entry.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            req_pend_r <= 1'b0;
        end else if (line_req) begin
            req_pend_r <= 1'b1;
        end else if (start_s) begin
            req_pend_r <= 1'b0;
        end else begin
            req_pend_r <= req_pend_r;
        end
    end

    // Burst scheduler: IDLE waits for a request and a full line, BURST reads exactly
    // LINE_LEN words back to back, GAP holds the read side idle for GAP_CYCLES.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_r      <= IDLE;
            pix_cnt_r    <= {LW{1'b0}};
            gap_cnt_r    <= 16'd0;
            rd_en_r      <= 1'b0;
            lines_done_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r   <= BURST;
                        pix_cnt_r <= {LW{1'b0}};
                        rd_en_r   <= 1'b1;
                    end else begin
                        rd_en_r   <= 1'b0;
                    end
                end
                BURST: begin
                    pix_cnt_r <= pix_cnt_r + LW'(1);
                    if (last_rd_s) begin
                        rd_en_r      <= 1'b0;
                        lines_done_r <= lines_done_r + 16'd1;
                        gap_cnt_r    <= 16'd0;
                        if (GAP_CYCLES > 0) begin
                            state_r <= GAP;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        rd_en_r <= 1'b1;
                    end
                end
                GAP: begin
                    rd_en_r <= 1'b0;
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rd_en_r <= 1'b0;
                end
            endcase
        end
    end

    // Read-side outputs follow the FIFO's one-cycle read latency; underflow is sticky.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            udf_err_r <= 1'b0;
        end else begin
            m_valid_r <= rd_en_r;
            m_last_r  <= rd_en_r && last_rd_s;
            udf_err_r <= udf_err_r || (rd_en_r && fifo_rd_empty);
        end
    end

    assign s_ready      = s_ready_s;
    assign fifo_wr_data = s_data;
    assign fifo_wr_en   = wr_en_s;
    assign fifo_rd_en   = rd_en_r;
    assign m_data       = fifo_rd_data;
    assign m_valid      = m_valid_r;
    assign m_last       = m_last_r;
    assign level        = level_r;
    assign lines_done   = lines_done_r;
    assign udf_err      = udf_err_r;

endmodule
